// File: rtl/rotor_inverse.sv
// Purpose : return-path rotor stage; maps a letter back through the inverse of a 26-entry wiring table at the current position.
// Latency : max(delay,1) cycles from an accepted valid to the done pulse; the table build takes 26 cycles after set.
// Backpr. : ready is high only in READY, and valid is ignored while ready is low. A lookup in flight, or a table build, blocks new input.
//
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   set                one-cycle pulse; latches wiring/offset/delay and rebuilds the inverse table
//   wiring             forward table, entry i = wiring[8i+7:8i]
//   offset             position step applied per en pulse (values 26..31 fold to 0..5)
//   delay              lookup latency in cycles (0 behaves as 1)
//   en                 advance the rotor position by the latched offset
//   valid, din         lookup request; din is accepted when ready is high
//   dout, done         inverse-mapped letter; done pulses for one cycle when dout updates
//   ready              block can accept a request
//   err                latched wiring is not a permutation
module rotor_inverse #(
   parameter int N = 26,
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             set,
   input  logic [N*W-1:0]   wiring,
   input  logic [4:0]       offset,
   input  logic [31:0]      delay,
   input  logic             en,
   input  logic             valid,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             done,
   output logic             ready,
   output logic             err
);

   localparam int PW = 5;
   localparam logic [W-1:0]  N_W   = W'(N);
   localparam logic [PW-1:0] N_P   = PW'(N);
   localparam logic [PW:0]   N_P1  = (PW+1)'(N);
   localparam logic [PW-1:0] LAST  = PW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUILD,
      S_READY,
      S_BUSY,
      S_FAULT
   } state_t;

   state_t state, state_nxt;

   // Latched configuration
   logic [N-1:0][W-1:0] wiring_q;
   logic [31:0]         delay_q;
   logic [PW-1:0]       off_q;

   // Rotor position and build bookkeeping
   logic [PW-1:0]       pos;
   logic [PW-1:0]       bidx;
   logic [N-1:0]        seen;
   logic                bad_q;
   logic [W-1:0]        inv [N];

   // Lookup in flight
   logic [W-1:0]        din_q;
   logic [PW-1:0]       pcap;
   logic [31:0]         cnt;

   // Combinational helpers
   logic [W-1:0]        w_cur;
   logic                entry_bad;
   logic                bad_any;
   logic                build_last;
   logic [31:0]         delay_eff;
   logic                busy_fin;
   logic [PW:0]         step_sum;
   logic [PW-1:0]       pos_step;
   logic [PW-1:0]       off_fold;
   logic [PW:0]         a_sum;
   logic [PW-1:0]       a_idx;
   logic [W-1:0]        inv_a;
   logic [W-1:0]        pc_w;
   logic [W-1:0]        result;

   // Build: an entry is bad if out of the alphabet or already claimed by an earlier entry.
   assign w_cur      = wiring_q[bidx];
   assign entry_bad  = (w_cur >= N_W) || seen[w_cur[PW-1:0]];
   assign bad_any    = bad_q | entry_bad;
   assign build_last = (bidx == LAST);

   assign delay_eff  = (delay_q == 32'd0) ? 32'd1 : delay_q;
   assign busy_fin   = (cnt >= delay_eff);

   // pos and off are both below N, so one conditional subtract keeps the sum in range.
   assign step_sum   = {1'b0, pos} + {1'b0, off_q};
   assign pos_step   = (step_sum >= N_P1) ? PW'(step_sum - N_P1) : step_sum[PW-1:0];
   assign off_fold   = (offset >= N_P) ? (offset - N_P) : offset;

   // Enter the table at (din + pos) mod N, then undo the position shift on the way out.
   assign a_sum      = {1'b0, din_q[PW-1:0]} + {1'b0, pcap};
   assign a_idx      = (a_sum >= N_P1) ? PW'(a_sum - N_P1) : a_sum[PW-1:0];
   assign inv_a      = inv[a_idx];
   assign pc_w       = W'(pcap);

   always_comb begin
      result = '0;
      if (din_q >= N_W) begin
         result = 8'hFF;
      end else if (inv_a >= pc_w) begin
         result = inv_a - pc_w;
      end else begin
         result = inv_a + N_W - pc_w;
      end
   end

   assign ready = (state == S_READY);
   assign err   = (state == S_FAULT);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; set overrides every state, including FAULT.
   always_comb begin
      state_nxt = state;
      if (set) begin
         state_nxt = S_BUILD;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_BUILD: begin
               if (build_last) begin
                  state_nxt = bad_any ? S_FAULT : S_READY;
               end
            end
            S_READY: begin
               if (valid) begin
                  state_nxt = S_BUSY;
               end
            end
            S_BUSY: begin
               if (busy_fin) begin
                  state_nxt = S_READY;
               end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wiring_q <= '0;
         delay_q  <= '0;
         off_q    <= '0;
         pos      <= '0;
         bidx     <= '0;
         seen     <= '0;
         bad_q    <= 1'b0;
         din_q    <= '0;
         pcap     <= '0;
         cnt      <= '0;
         dout     <= '0;
         done     <= 1'b0;
         for (int k = 0; k < N; k++) begin
            inv[k] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (set) begin
            // Any lookup in flight is dropped here; its done never fires.
            wiring_q <= wiring;
            delay_q  <= delay;
            off_q    <= off_fold;
            pos      <= '0;
            bidx     <= '0;
            seen     <= '0;
            bad_q    <= 1'b0;
            cnt      <= '0;
         end else begin
            case (state)
               S_BUILD: begin
                  if (w_cur < N_W) begin
                     inv[w_cur[PW-1:0]]  <= W'(bidx);
                     seen[w_cur[PW-1:0]] <= 1'b1;
                  end
                  bad_q <= bad_any;
                  bidx  <= bidx + PW'(1);
               end
               S_READY: begin
                  if (valid) begin
                     // Capture the pre-step position, even if en steps it at this same edge.
                     din_q <= din;
                     pcap  <= pos;
                     cnt   <= 32'd1;
                  end
               end
               S_BUSY: begin
                  if (busy_fin) begin
                     dout <= result;
                     done <= 1'b1;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               default: ;
            endcase
            if (en && (state == S_READY || state == S_BUSY)) begin
               pos <= pos_step;
            end
         end
      end
   end

endmodule

// File: doc/rotor_inverse.md
Name: rotor_inverse

Overview:
- Return-path (reflector-to-entry) stage of the enigma datapath.
- Maps a letter index backward through one rotor's wiring, i.e. applies the inverse permutation of the 26-entry wiring table at the current rotor position.
- Builds the inverse table internally from the same wiring/offset/delay configuration that forward rotors receive.
- Uses a valid/done handshake with a programmable delay, so it slots into the same stage chain as forward rotors.

Parameters:
- N, 26, alphabet size; wiring entries and positions are 0..N-1.
- W, 8, bits per letter index and per wiring entry.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- set  input  1  1-cycle pulse; latch wiring/offset/delay and start table build.
- wiring  input  208  forward table; entry i = wiring[8i+7:8i].
- offset  input  5  position step per en pulse; must be <26.
- delay  input  32  lookup latency in cycles.
- en  input  1  step rotor position by offset.
- valid  input  1  din valid; accepted only when ready=1.
- din  input  8  letter index entering from reflector side.
- dout  output  8  inverse-mapped letter index.
- done  output  1  1-cycle pulse; dout is valid this cycle.
- ready  output  1  block can accept valid.
- err  output  1  latched wiring is not a permutation.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, pos=0, inverse table cleared, dout=0, done=0, ready=0, err=0.
- States: IDLE, BUILD, READY, BUSY, FAULT.
- set (from any state):
  - Latches wiring, delay, and offset as off = (offset>=26 ? offset-26 : offset).
  - Clears pos to 0, clears err, drops ready, aborts any in-flight lookup (no done), enters BUILD with i=0.
- BUILD (exactly 26 cycles, one entry per cycle):
  - Per entry: inv[W[i]] <= i; seen[W[i]] <= 1.
  - Entry flagged bad if W[i]>=26 or seen[W[i]] is already set.
  - After i=25: any bad entry -> FAULT (err=1, ready=0); otherwise -> READY (ready=1).
  - ready rises on the cycle after the last build write.
- FAULT: ignores valid and en; left only by set or reset.
- Stepping:
  - en in READY or BUSY: pos <= pos+off; if result >=26, subtract 26.
  - en is ignored in IDLE, BUILD, and FAULT.
  - Single subtraction suffices because pos and off are both <26.
- Accept:
  - valid with ready=1 at edge t: capture din and the current pos (pre-step if en is high at the same edge), set cnt=1, go to BUSY, ready=0.
  - valid with ready=0 is ignored; no done.
- BUSY:
  - cnt increments each cycle.
  - When cnt >= delay (delay 0 treated as 1): dout <= result, done=1 for one cycle, return to READY with ready=1.
  - Net effect: done asserts max(delay,1) cycles after edge t.
- Result:
  - a = (din+pcap) mod 26; result = (inv[a] - pcap) mod 26, both via single conditional add/subtract of 26.
  - din>=26: result = 8'hFF, err unchanged.
- dout holds its last value between done pulses; done never asserts for two consecutive cycles.
- Back-to-back: valid may be asserted in the same cycle done is high, since ready is already 1; it is accepted.
- Reset mid-BUILD or mid-BUSY: everything returns to reset values; no done.

Test Plan:
- Identity wiring (W[i]=i), offset=1, delay=1, set, wait 26 cycles, din=7 -> ready high; done 1 cycle after valid with dout=7. Then 3 en pulses (pos=3), din=7 -> dout=7.
- Enigma rotor I wiring "EKMFLGDQVZNTOWYHXUSPAIBRCJ", pos=0, din=4 -> dout=0. One en with offset=1 (pos=1), din=4 -> dout=2.
- delay=3, valid at edge t -> done exactly at t+3, ready low at t+1..t+2. Valid during BUSY -> ignored, no extra done.
- Wrap-around: offset=25, two en pulses -> pos=24 (25, then 50-26). offset=27 latched as 1.
- Wiring with W[3]=W[5]=4 -> after 26 cycles err=1, ready=0; valid -> no done. New set with valid wiring -> err=0, ready=1.
- reset_n low mid-BUILD and mid-BUSY -> all outputs 0 immediately; no done after release until set.
